// File: rtl/rvh_l1d_amo_seq.sv
// ----------------------------------------------------------------------------
// rvh_l1d_amo_seq
// L1D atomic / LR-SC sequencer placed between the LSU store pipes and the
// store buffer. Ordinary stores pass straight through. The lowest-index AMO,
// LR or SC is captured and replayed on STB port 0 as fence, request, fence.
// The sequencer then waits for the request's ROB tag on any writeback port.
// A single-line LR reservation is kept and drives the SC success check.
//
// Optional feature macro: AMO_SEQ_RSV_TIMEOUT_EN
//   When defined, the reservation expires RSV_TIMEOUT cycles after it is set.
//   This bounds LR livelock.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   ls_st_req_*_i / _rdy_o        LSU store requests (port order = program order)
//   stb_st_req_*_o / _rdy_i       requests to the store buffer
//   stb_st_req_no_fence_wb_resp_o fence is sequencer-internal, no ROB response
//   stb_st_req_sc_rt_check_succ_o latched SC hits a valid reservation
//   wb_vld_i / wb_rob_tag_i       writeback ports searched for AMO completion
//   snp_inv_*_i, evict_*_i        line-granular reservation kills
//   in_amo_state_o, rsv_valid_o   status
//
// Opcode map (STU_OP_WIDTH bits): 0..3 plain stores, 4 LRW, 5 LRD, 6 SCW,
// 7 SCD, 8..25 AMOSWAP/ADD/AND/OR/XOR/MAX/MAXU/MIN/MINU (W then D).
// ----------------------------------------------------------------------------
module rvh_l1d_amo_seq #(
    parameter int N_ST_IN_PORT        = 2,
    parameter int LSU_DATA_PIPE_COUNT = 2,
    parameter int N_WB_PORT           = LSU_DATA_PIPE_COUNT,
    parameter int LINE_OFFSET_W       = 6,
    parameter int RSV_TIMEOUT         = 255,
    parameter int ROB_TAG_WIDTH       = 6,
    parameter int PREG_TAG_WIDTH      = 7,
    parameter int STU_OP_WIDTH        = 5,
    parameter int PADDR_WIDTH         = 56,
    parameter int XLEN                = 64
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_ST_IN_PORT-1:0]                ls_st_req_vld_i,
    input  logic [N_ST_IN_PORT-1:0]                ls_st_req_is_fence_i,
    input  logic [N_ST_IN_PORT*ROB_TAG_WIDTH-1:0]  ls_st_req_rob_tag_i,
    input  logic [N_ST_IN_PORT*PREG_TAG_WIDTH-1:0] ls_st_req_prd_i,
    input  logic [N_ST_IN_PORT*STU_OP_WIDTH-1:0]   ls_st_req_opcode_i,
    input  logic [N_ST_IN_PORT*PADDR_WIDTH-1:0]    ls_st_req_paddr_i,
    input  logic [N_ST_IN_PORT*XLEN-1:0]           ls_st_req_data_i,
    output logic [N_ST_IN_PORT-1:0]                ls_st_req_rdy_o,
    output logic [N_ST_IN_PORT-1:0]                stb_st_req_vld_o,
    output logic [N_ST_IN_PORT-1:0]                stb_st_req_is_fence_o,
    output logic [N_ST_IN_PORT*ROB_TAG_WIDTH-1:0]  stb_st_req_rob_tag_o,
    output logic [N_ST_IN_PORT*PREG_TAG_WIDTH-1:0] stb_st_req_prd_o,
    output logic [N_ST_IN_PORT*STU_OP_WIDTH-1:0]   stb_st_req_opcode_o,
    output logic [N_ST_IN_PORT*PADDR_WIDTH-1:0]    stb_st_req_paddr_o,
    output logic [N_ST_IN_PORT*XLEN-1:0]           stb_st_req_data_o,
    output logic                                   stb_st_req_no_fence_wb_resp_o,
    output logic                                   stb_st_req_sc_rt_check_succ_o,
    input  logic [N_ST_IN_PORT-1:0]                stb_st_req_rdy_i,
    input  logic [N_WB_PORT-1:0]                   wb_vld_i,
    input  logic [N_WB_PORT*ROB_TAG_WIDTH-1:0]     wb_rob_tag_i,
    input  logic                                   snp_inv_vld_i,
    input  logic [PADDR_WIDTH-LINE_OFFSET_W-1:0]   snp_inv_line_i,
    input  logic                                   evict_vld_i,
    input  logic [PADDR_WIDTH-LINE_OFFSET_W-1:0]   evict_line_i,
    output logic                                   in_amo_state_o,
    output logic                                   rsv_valid_o
);

    localparam int LINE_W = PADDR_WIDTH - LINE_OFFSET_W;

    generate
        if (N_ST_IN_PORT < 1 || N_ST_IN_PORT > 4 || RSV_TIMEOUT < 1) begin : g_bad_cfg
            $error("rvh_l1d_amo_seq: unsupported parameter configuration");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FLUSH1 = 3'd1,
        S_SEND   = 3'd2,
        S_FLUSH2 = 3'd3,
        S_WAIT   = 3'd4
    } state_t;

    function automatic logic f_is_amo(input logic [STU_OP_WIDTH-1:0] op);
        return (op >= STU_OP_WIDTH'(4)) && (op <= STU_OP_WIDTH'(25));
    endfunction

    state_t                    r_state, w_state_nxt;
    logic [ROB_TAG_WIDTH-1:0]  r_rob_tag;
    logic [PREG_TAG_WIDTH-1:0] r_prd;
    logic [STU_OP_WIDTH-1:0]   r_opcode;
    logic [PADDR_WIDTH-1:0]    r_paddr;
    logic [XLEN-1:0]           r_data;
    logic                      r_is_lr, r_is_sc;
    logic                      r_rsv_valid;
    logic [LINE_W-1:0]         r_rsv_line;

    logic [N_ST_IN_PORT-1:0]   w_amo_vec, w_first, w_pass;
    logic                      w_seen, w_accept;
    logic [ROB_TAG_WIDTH-1:0]  w_sel_rob_tag;
    logic [PREG_TAG_WIDTH-1:0] w_sel_prd;
    logic [STU_OP_WIDTH-1:0]   w_sel_opcode;
    logic [PADDR_WIDTH-1:0]    w_sel_paddr;
    logic [XLEN-1:0]           w_sel_data;
    logic                      w_cmpl, w_rsv_set, w_rsv_clr, w_st_hit;
    logic [LINE_W-1:0]         w_cmp_line;

    // w_first marks the lowest-index valid AMO; w_pass marks ports ahead of it
    // in program order (all ports when no AMO is present).
    always_comb begin
        w_seen    = 1'b0;
        w_amo_vec = '0;
        w_first   = '0;
        w_pass    = '0;
        for (int unsigned p = 0; p < N_ST_IN_PORT; p++) begin
            w_amo_vec[p] = ls_st_req_vld_i[p] & ~ls_st_req_is_fence_i[p]
                         & f_is_amo(ls_st_req_opcode_i[p*STU_OP_WIDTH +: STU_OP_WIDTH]);
            if (w_amo_vec[p] && !w_seen) w_first[p] = 1'b1;
            if (w_amo_vec[p]) w_seen = 1'b1;
            w_pass[p] = ~w_seen;
        end
    end

    // The AMO may only leave the LSU together with every older store.
    assign w_accept = (|w_first) & ~(|(ls_st_req_vld_i & w_pass & ~stb_st_req_rdy_i));

    always_comb begin
        w_sel_rob_tag = '0;
        w_sel_prd     = '0;
        w_sel_opcode  = '0;
        w_sel_paddr   = '0;
        w_sel_data    = '0;
        for (int unsigned p = 0; p < N_ST_IN_PORT; p++) begin
            if (w_first[p]) begin
                w_sel_rob_tag = ls_st_req_rob_tag_i[p*ROB_TAG_WIDTH +: ROB_TAG_WIDTH];
                w_sel_prd     = ls_st_req_prd_i[p*PREG_TAG_WIDTH +: PREG_TAG_WIDTH];
                w_sel_opcode  = ls_st_req_opcode_i[p*STU_OP_WIDTH +: STU_OP_WIDTH];
                w_sel_paddr   = ls_st_req_paddr_i[p*PADDR_WIDTH +: PADDR_WIDTH];
                w_sel_data    = ls_st_req_data_i[p*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        w_cmpl = 1'b0;
        for (int unsigned w = 0; w < N_WB_PORT; w++) begin
            if (wb_vld_i[w] && wb_rob_tag_i[w*ROB_TAG_WIDTH +: ROB_TAG_WIDTH] == r_rob_tag)
                w_cmpl = 1'b1;
        end
        w_cmpl = w_cmpl & (r_state == S_WAIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rob_tag <= '0;
            r_prd     <= '0;
            r_opcode  <= '0;
            r_paddr   <= '0;
            r_data    <= '0;
            r_is_lr   <= 1'b0;
            r_is_sc   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_accept) begin
                r_rob_tag <= w_sel_rob_tag;
                r_prd     <= w_sel_prd;
                r_opcode  <= w_sel_opcode;
                r_paddr   <= w_sel_paddr;
                r_data    <= w_sel_data;
                r_is_lr   <= (w_sel_opcode == STU_OP_WIDTH'(4)) || (w_sel_opcode == STU_OP_WIDTH'(5));
                r_is_sc   <= (w_sel_opcode == STU_OP_WIDTH'(6)) || (w_sel_opcode == STU_OP_WIDTH'(7));
            end
        end
    end

    always_comb begin
        w_state_nxt                   = r_state;
        ls_st_req_rdy_o               = '0;
        stb_st_req_vld_o              = '0;
        stb_st_req_is_fence_o         = ls_st_req_is_fence_i;
        stb_st_req_rob_tag_o          = ls_st_req_rob_tag_i;
        stb_st_req_prd_o              = ls_st_req_prd_i;
        stb_st_req_opcode_o           = ls_st_req_opcode_i;
        stb_st_req_paddr_o            = ls_st_req_paddr_i;
        stb_st_req_data_o             = ls_st_req_data_i;
        stb_st_req_no_fence_wb_resp_o = 1'b0;
        in_amo_state_o                = 1'b0;
        if (r_state == S_IDLE) begin
            stb_st_req_vld_o = ls_st_req_vld_i & w_pass;
            ls_st_req_rdy_o  = (stb_st_req_rdy_i & w_pass) | (w_first & {N_ST_IN_PORT{w_accept}});
            if (w_accept) w_state_nxt = S_FLUSH1;
        end else begin
            stb_st_req_no_fence_wb_resp_o                = 1'b1;
            in_amo_state_o                               = 1'b1;
            stb_st_req_rob_tag_o[0 +: ROB_TAG_WIDTH]     = r_rob_tag;
            stb_st_req_prd_o[0 +: PREG_TAG_WIDTH]        = r_prd;
            stb_st_req_opcode_o[0 +: STU_OP_WIDTH]       = r_opcode;
            stb_st_req_paddr_o[0 +: PADDR_WIDTH]         = r_paddr;
            stb_st_req_data_o[0 +: XLEN]                 = r_data;
            stb_st_req_is_fence_o[0]                     = (r_state != S_SEND);
            case (r_state)
                S_FLUSH1: begin
                    stb_st_req_vld_o[0] = 1'b1;
                    if (stb_st_req_rdy_i[0]) w_state_nxt = S_SEND;
                end
                S_SEND: begin
                    stb_st_req_vld_o[0] = 1'b1;
                    if (stb_st_req_rdy_i[0]) w_state_nxt = S_FLUSH2;
                end
                S_FLUSH2: begin
                    stb_st_req_vld_o[0] = 1'b1;
                    if (stb_st_req_rdy_i[0]) w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (w_cmpl) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Kills are compared against the line being reserved when a set happens
    // in the same cycle, so a same-cycle clear overrides the new reservation.
    assign w_rsv_set  = w_cmpl & r_is_lr;
    assign w_cmp_line = w_rsv_set ? r_paddr[PADDR_WIDTH-1:LINE_OFFSET_W] : r_rsv_line;

    always_comb begin
        w_st_hit = 1'b0;
        for (int unsigned p = 0; p < N_ST_IN_PORT; p++) begin
            if (stb_st_req_vld_o[p] && stb_st_req_rdy_i[p] && !stb_st_req_is_fence_o[p]
                && stb_st_req_paddr_o[p*PADDR_WIDTH+LINE_OFFSET_W +: LINE_W] == w_cmp_line
                && !(p == 0 && r_state == S_SEND && r_is_lr))
                w_st_hit = 1'b1;
        end
    end

    assign w_rsv_clr = w_st_hit
                     | (w_cmpl & r_is_sc)
                     | (snp_inv_vld_i & (snp_inv_line_i == w_cmp_line))
                     | (evict_vld_i & (evict_line_i == w_cmp_line));

`ifdef AMO_SEQ_RSV_TIMEOUT_EN
    localparam int CNT_W = $clog2(RSV_TIMEOUT + 1);
    logic [CNT_W-1:0] r_rsv_cnt;
    logic             w_expire;

    assign w_expire = r_rsv_valid & (r_rsv_cnt == CNT_W'(RSV_TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsv_valid <= 1'b0;
            r_rsv_line  <= '0;
            r_rsv_cnt   <= '0;
        end else begin
            if (w_rsv_set) r_rsv_line <= r_paddr[PADDR_WIDTH-1:LINE_OFFSET_W];
            if (w_rsv_clr)      r_rsv_valid <= 1'b0;
            else if (w_rsv_set) r_rsv_valid <= 1'b1;
            else if (w_expire)  r_rsv_valid <= 1'b0;
            if (w_rsv_set)                    r_rsv_cnt <= '0;
            else if (r_rsv_valid && !w_expire) r_rsv_cnt <= r_rsv_cnt + 1'b1;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsv_valid <= 1'b0;
            r_rsv_line  <= '0;
        end else begin
            if (w_rsv_set) r_rsv_line <= r_paddr[PADDR_WIDTH-1:LINE_OFFSET_W];
            if (w_rsv_clr)      r_rsv_valid <= 1'b0;
            else if (w_rsv_set) r_rsv_valid <= 1'b1;
        end
    end
`endif

    assign rsv_valid_o = r_rsv_valid;
    assign stb_st_req_sc_rt_check_succ_o = r_is_sc & r_rsv_valid
                                         & (r_rsv_line == r_paddr[PADDR_WIDTH-1:LINE_OFFSET_W]);

endmodule
